mem_arbiter: RTL and testbench

//  Owns the single main-memory port shared by the I-cache and D-cache.
//  - Grants one requester at a time; services D-cache write-through stores.
//  - Sequences block fills: issues BLOCK_WORDS pipelined reads and steers

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter_if.sv | 22 ++
 rtl/mem_arbiter_fill_counter.sv | 29 ++
 rtl/mem_arbiter.sv | 104 ++++++++++
 tb/tb_mem_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared sizes, FSM/grant encodings and block-address helper for mem_arbiter
//   ADDR_W/DATA_W : byte-address and word widths of the memory port
//   BLOCK_WORDS   : words per cache block (power of 2)
//   WORD_BITS     : width of a word offset inside a block
//   OFF_BITS      : width of a byte offset inside a block
package mem_arbiter_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int BLOCK_WORDS = 8;
    localparam int WORD_BITS   = $clog2(BLOCK_WORDS);
    localparam int OFF_BITS    = WORD_BITS + 1;

    typedef enum logic [2:0] {IDLE, STORE, ISSUE, DRAIN, DONE} stateT;

    // A store is always a D-cache operation, so it shares GNT_DC.
    typedef enum logic [1:0] {GNT_NONE, GNT_IC, GNT_DC} grantT;

    function automatic logic [ADDR_W-1:0] blockBase(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'((1 << OFF_BITS) - 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: single main-memory port owned by mem_arbiter
//   mem_en     : access this cycle
//   mem_wr     : 1 = write, 0 = read (valid with mem_en)
//   mem_addr   : byte address
//   mem_wdata  : write data
//   mem_rdata  : read data returned by memory
//   mem_rvalid : mem_rdata valid
//   master     : arbiter side, slave : memory side
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;

    modport master (output mem_en, mem_wr, mem_addr, mem_wdata, input mem_rdata, mem_rvalid);
    modport slave  (input mem_en, mem_wr, mem_addr, mem_wdata, output mem_rdata, mem_rvalid);

endinterface

// File: rtl/mem_arbiter_fill_counter.sv
// block_fill_counter: word counter for a block fill (issue or receive side)
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : restart the count at word 0
//   inc        : advance one word
//   cnt        : current word offset
//   last       : inc on the final word of the block (terminal count)
module block_fill_counter #(
    parameter int BLOCK_WORDS = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic                           inc,
    output logic [$clog2(BLOCK_WORDS)-1:0] cnt,
    output logic                           last
);

    localparam int W = $clog2(BLOCK_WORDS);

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 1'b1;
    end

    assign last = inc && cnt == W'(BLOCK_WORDS - 1);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: owns the shared memory port for I-cache/D-cache fills and D-cache write-through stores
//   clk, rst_n               : clock, synchronous active-low reset
//   ic_miss, ic_miss_addr    : I-cache miss request (held until ic_tag_we)
//   dc_miss, dc_miss_addr    : D-cache miss request (held until dc_tag_we)
//   dc_store, dc_store_addr,
//   dc_store_data            : write-through store (held until store_ack)
//   mem                      : memory port (mem_arbiter_if.master)
//   fill_data, fill_word     : returned word and its offset in the block
//   ic_fill_we, dc_fill_we   : data-array write strobes
//   ic_tag_we, dc_tag_we     : fill-complete tag/valid write pulses
//   store_ack                : store issued to memory
//   cache_stall              : freeze the pipeline
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ic_miss,
    input  logic [ADDR_W-1:0]    ic_miss_addr,
    input  logic                 dc_miss,
    input  logic [ADDR_W-1:0]    dc_miss_addr,
    input  logic                 dc_store,
    input  logic [ADDR_W-1:0]    dc_store_addr,
    input  logic [DATA_W-1:0]    dc_store_data,
    mem_arbiter_if.master        mem,
    output logic [DATA_W-1:0]    fill_data,
    output logic [WORD_BITS-1:0] fill_word,
    output logic                 ic_fill_we,
    output logic                 dc_fill_we,
    output logic                 ic_tag_we,
    output logic                 dc_tag_we,
    output logic                 store_ack,
    output logic                 cache_stall
);

    stateT                state, nextState;
    grantT                grant;
    logic [ADDR_W-1:0]    addrQ;
    logic [DATA_W-1:0]    dataQ;
    logic [WORD_BITS-1:0] issueCnt, recvCnt;
    logic                 issueInc, recvInc, issueLast, recvLast;

    assign issueInc = state == ISSUE;
    // Returns are only meaningful while a fill is in flight; anything else is stale.
    assign recvInc  = (state == ISSUE || state == DRAIN) && mem.mem_rvalid;

    block_fill_counter #(.BLOCK_WORDS(BLOCK_WORDS)) issueCtr (
        .clk(clk), .rst_n(rst_n), .clr(state == IDLE), .inc(issueInc), .cnt(issueCnt), .last(issueLast)
    );

    block_fill_counter #(.BLOCK_WORDS(BLOCK_WORDS)) recvCtr (
        .clk(clk), .rst_n(rst_n), .clr(state == IDLE), .inc(recvInc), .cnt(recvCnt), .last(recvLast)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nextState;
    end

    // Re-latched every IDLE cycle, so the values held on leaving IDLE belong to the granted request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant <= GNT_NONE;
            addrQ <= '0;
            dataQ <= '0;
        end else if (state == IDLE) begin
            grant <= (dc_store || dc_miss) ? GNT_DC : ic_miss ? GNT_IC : GNT_NONE;
            addrQ <= dc_store ? dc_store_addr : blockBase(dc_miss ? dc_miss_addr : ic_miss_addr);
            dataQ <= dc_store_data;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    nextState = dc_store ? STORE : (dc_miss || ic_miss) ? ISSUE : IDLE;
            STORE:   nextState = IDLE;
            // The final return can only overtake the final issue with a very short memory latency.
            ISSUE:   nextState = recvLast ? DONE : issueLast ? DRAIN : ISSUE;
            DRAIN:   nextState = recvLast ? DONE : DRAIN;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        mem.mem_en    = state == STORE || state == ISSUE;
        mem.mem_wr    = state == STORE;
        // Block base is aligned, so OR-ing in the word offset forms the address.
        mem.mem_addr  = state == STORE ? addrQ : state == ISSUE ? addrQ | ADDR_W'({issueCnt, 1'b0}) : '0;
        mem.mem_wdata = state == STORE ? dataQ : '0;
        fill_data     = recvInc ? mem.mem_rdata : '0;
        fill_word     = recvInc ? recvCnt : '0;
        ic_fill_we    = recvInc && grant == GNT_IC;
        dc_fill_we    = recvInc && grant == GNT_DC;
        ic_tag_we     = state == DONE && grant == GNT_IC;
        dc_tag_we     = state == DONE && grant == GNT_DC;
        store_ack     = state == STORE;
        cache_stall   = state != IDLE || ic_miss || dc_miss || dc_store;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a cycle-schedule model
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int LAT  = 4;
    localparam int BW   = BLOCK_WORDS;
    localparam int FILL = BW + LAT + 2;
    localparam int MAXC = 48;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ic_miss = 1'b0, dc_miss = 1'b0, dc_store = 1'b0;
    logic [15:0] ic_miss_addr = '0, dc_miss_addr = '0, dc_store_addr = '0, dc_store_data = '0;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        ic_fill_we, dc_fill_we, ic_tag_we, dc_tag_we, store_ack, cache_stall;

    always #5 clk = ~clk;

    mem_arbiter_if mb();

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ic_miss(ic_miss), .ic_miss_addr(ic_miss_addr),
        .dc_miss(dc_miss), .dc_miss_addr(dc_miss_addr),
        .dc_store(dc_store), .dc_store_addr(dc_store_addr), .dc_store_data(dc_store_data),
        .mem(mb),
        .fill_data(fill_data), .fill_word(fill_word),
        .ic_fill_we(ic_fill_we), .dc_fill_we(dc_fill_we),
        .ic_tag_we(ic_tag_we), .dc_tag_we(dc_tag_we),
        .store_ack(store_ack), .cache_stall(cache_stall)
    );

    // Memory: word array with unwritten words derived from a seed, reads return LAT cycles later.
    logic [15:0] memArr [32768];
    bit          written [32768];
    logic [15:0] seed = '0;
    logic [3:0]  rvPipe = '0;
    logic [15:0] rdPipe [4];
    logic        inject = 1'b0;
    logic [15:0] injData = '0;

    function automatic logic [15:0] memWord(input int idx);
        return written[idx] ? memArr[idx] : (16'(idx * 40503) ^ seed);
    endfunction

    always @(posedge clk) begin
        if (mb.mem_en === 1'b1 && mb.mem_wr === 1'b1) begin
            memArr[int'(mb.mem_addr[15:1])]  <= mb.mem_wdata;
            written[int'(mb.mem_addr[15:1])] <= 1'b1;
        end
        rvPipe    <= {rvPipe[2:0], mb.mem_en === 1'b1 && mb.mem_wr === 1'b0};
        rdPipe[0] <= memWord(int'(mb.mem_addr[15:1]));
        for (int i = 1; i < 4; i++) rdPipe[i] <= rdPipe[i-1];
    end

    assign mb.mem_rvalid = rvPipe[3] | inject;
    assign mb.mem_rdata  = inject ? injData : rdPipe[3];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle schedule, cycle 0 = the cycle the requests first appear.
    bit          eEn[MAXC], eWr[MAXC], eAck[MAXC], eIcF[MAXC], eDcF[MAXC], eIcT[MAXC], eDcT[MAXC], eStall[MAXC];
    logic [15:0] eAddr[MAXC], eWd[MAXC], eFd[MAXC];
    logic [2:0]  eFw[MAXC];

    task automatic planFill(input int g, input bit isDc, input logic [15:0] a,
                            input bit doSt, input logic [15:0] sAddr, input logic [15:0] sData);
        logic [15:0] base, wa;
        base = a & 16'hFFF0;
        for (int k = 0; k < BW; k++) begin
            wa = base + 16'(2 * k);
            eEn[g+1+k]   = 1'b1;
            eAddr[g+1+k] = wa;
            eFw[g+1+LAT+k] = 3'(k);
            eFd[g+1+LAT+k] = (doSt && sAddr[15:1] == wa[15:1]) ? sData : memWord(int'(wa[15:1]));
            if (isDc) eDcF[g+1+LAT+k] = 1'b1;
            else      eIcF[g+1+LAT+k] = 1'b1;
        end
        if (isDc) eDcT[g+FILL-1] = 1'b1;
        else      eIcT[g+FILL-1] = 1'b1;
    endtask

    task automatic runScenario(input string name, input bit doSt, input bit doDc, input bit doIc,
                               input logic [15:0] sAddr, input logic [15:0] sData,
                               input logic [15:0] dAddr, input logic [15:0] iAddr);
        int g = 0, stEnd = -1, dcEnd = -1, icEnd = -1;
        for (int c = 0; c < MAXC; c++) begin
            eEn[c] = 0; eWr[c] = 0; eAck[c] = 0; eIcF[c] = 0; eDcF[c] = 0;
            eIcT[c] = 0; eDcT[c] = 0; eStall[c] = 0;
            eAddr[c] = '0; eWd[c] = '0; eFd[c] = '0; eFw[c] = '0;
        end
        if (doSt) begin
            eEn[g+1] = 1; eWr[g+1] = 1; eAck[g+1] = 1; eAddr[g+1] = sAddr; eWd[g+1] = sData;
            stEnd = g + 1;
            g += 2;
        end
        if (doDc) begin
            planFill(g, 1'b1, dAddr, doSt, sAddr, sData);
            dcEnd = g + FILL - 1;
            g += FILL;
        end
        if (doIc) begin
            planFill(g, 1'b0, iAddr, doSt, sAddr, sData);
            icEnd = g + FILL - 1;
            g += FILL;
        end
        for (int c = 0; c < g; c++) eStall[c] = 1;
        for (int c = 0; c <= g; c++) begin
            dc_store = doSt && c <= stEnd;
            dc_miss  = doDc && c <= dcEnd;
            ic_miss  = doIc && c <= icEnd;
            dc_store_addr = sAddr; dc_store_data = sData;
            dc_miss_addr  = dAddr; ic_miss_addr  = iAddr;
            @(negedge clk);
            chk($sformatf("%s c%0d mem_en", name, c), mb.mem_en, eEn[c]);
            chk($sformatf("%s c%0d store_ack", name, c), store_ack, eAck[c]);
            chk($sformatf("%s c%0d ic_fill_we", name, c), ic_fill_we, eIcF[c]);
            chk($sformatf("%s c%0d dc_fill_we", name, c), dc_fill_we, eDcF[c]);
            chk($sformatf("%s c%0d ic_tag_we", name, c), ic_tag_we, eIcT[c]);
            chk($sformatf("%s c%0d dc_tag_we", name, c), dc_tag_we, eDcT[c]);
            chk($sformatf("%s c%0d cache_stall", name, c), cache_stall, eStall[c]);
            if (eEn[c]) begin
                chk($sformatf("%s c%0d mem_wr", name, c), mb.mem_wr, eWr[c]);
                chk($sformatf("%s c%0d mem_addr", name, c), mb.mem_addr, eAddr[c]);
            end
            if (eWr[c]) chk($sformatf("%s c%0d mem_wdata", name, c), mb.mem_wdata, eWd[c]);
            if (eIcF[c] || eDcF[c]) begin
                chk($sformatf("%s c%0d fill_word", name, c), fill_word, eFw[c]);
                chk($sformatf("%s c%0d fill_data", name, c), fill_data, eFd[c]);
            end
            nextCycle();
        end
    endtask

    task automatic chkIdle(input string tag);
        chk({tag, " mem_en"}, mb.mem_en, 1'b0);
        chk({tag, " ic_fill_we"}, ic_fill_we, 1'b0);
        chk({tag, " dc_fill_we"}, dc_fill_we, 1'b0);
        chk({tag, " ic_tag_we"}, ic_tag_we, 1'b0);
        chk({tag, " dc_tag_we"}, dc_tag_we, 1'b0);
        chk({tag, " store_ack"}, store_ack, 1'b0);
        chk({tag, " cache_stall"}, cache_stall, 1'b0);
    endtask

    initial begin
        bit          rs, rd, ri;
        logic [15:0] ra, rv, rda, ria;
        seed = 16'($urandom);
        // Reset held 3 cycles while stale read data keeps arriving.
        rst_n = 1'b0;
        inject = 1'b1;
        nextCycle();
        for (int r = 0; r < 3; r++) begin
            injData = 16'($urandom);
            @(negedge clk);
            chkIdle($sformatf("reset r%0d", r));
            nextCycle();
        end
        rst_n = 1'b1;
        injData = 16'($urandom);
        @(negedge clk);
        chkIdle("idle stale");
        nextCycle();
        inject = 1'b0;

        runScenario("ic1234", 0, 0, 1, 16'h0, 16'h0, 16'h0, 16'h1234);
        runScenario("store40", 1, 0, 0, 16'h0040, 16'hBEEF, 16'h0, 16'h0);
        @(negedge clk);
        chkIdle("after store");
        nextCycle();
        runScenario("dc_ic", 0, 1, 1, 16'h0, 16'h0, 16'h2046, 16'h3018);
        runScenario("st_dc", 1, 1, 0, 16'h5006, 16'h1111, 16'h500A, 16'h0);

        // Reset during DRAIN just after word 5 has been returned.
        dc_miss = 1'b1;
        dc_miss_addr = 16'h7788;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            chk($sformatf("abort c%0d dc_tag_we", c), dc_tag_we, 1'b0);
            if (c == 10) begin
                chk("abort word5 dc_fill_we", dc_fill_we, 1'b1);
                chk("abort word5 fill_word", fill_word, 3'd5);
            end
            nextCycle();
        end
        rst_n = 1'b0;
        dc_miss = 1'b0;
        nextCycle();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chkIdle($sformatf("abort post c%0d", c));
            nextCycle();
        end
        runScenario("abort_refill", 0, 1, 0, 16'h0, 16'h0, 16'h7788, 16'h0);

        for (int it = 0; it < 20; it++) begin
            rs = 1'($urandom); rd = 1'($urandom); ri = 1'($urandom);
            if (!(rs || rd || ri)) ri = 1'b1;
            ra  = 16'($urandom) & 16'hFFFE;
            rv  = 16'($urandom);
            rda = (it % 3 == 0) ? ((ra & 16'hFFF0) | 16'($urandom_range(0, 15))) : 16'($urandom);
            ria = 16'($urandom);
            runScenario($sformatf("rnd%0d", it), rs, rd, ri, ra, rv, rda, ria);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
